// File: rtl/debug_display_mux.sv
// debug_display_mux: picks one channel's 7-segment pattern (manual or auto-scroll) for a debug display
module debug_display_mux #(
    parameter int N_CH        = 8,
    parameter int DIGITS      = 2,
    parameter int REFRESH_DIV = 5000000,
    parameter int SCROLL_DIV  = 20
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_CH*DIGITS*8-1:0]   seg_in,
    input  logic [N_CH-1:0]            dsw,
    input  logic                       auto,
    input  logic                       freeze,
    output logic [DIGITS*8-1:0]        seg_out,
    output logic [$clog2(N_CH)-1:0]    ch_idx,
    output logic                       valid
);
    localparam int CW = $clog2(N_CH);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int SW = $clog2(SCROLL_DIV + 1);
    localparam int DW = DIGITS * 8;
    localparam logic [DW-1:0] DASH = {DIGITS{8'b1011_1111}};
    localparam logic [DW-1:0] DP0  = DW'(8'h80);

    logic [RW-1:0] rcnt;
    logic [SW-1:0] scnt;
    logic [CW-1:0] ptr, nxt_ptr, man_idx, sel_idx, prev_idx;
    logic [DW-1:0] seg_q;
    logic [1:0]    up;
    logic          auto_q, flip, prev_ok, man_ok, sel_ok;
    logic          tick, rise, adv, chg, upd, load;
    int            n_set;

    // one-hot decode of the manual switches; zero or several set bits is invalid
    always_comb begin
        man_idx = '0;
        n_set = 0;
        for (int k = 0; k < N_CH; k++)
            if (dsw[k]) begin
                man_idx = CW'(k);
                n_set = n_set + 1;
            end
        man_ok = (n_set == 1);
    end

    assign tick    = rcnt == RW'(REFRESH_DIV - 1);
    assign rise    = auto & ~auto_q;
    assign adv     = auto & ~rise & tick & (scnt == SW'(SCROLL_DIV - 1));
    assign nxt_ptr = ptr == CW'(N_CH - 1) ? '0 : ptr + 1'b1;
    assign sel_ok  = auto | man_ok;
    assign sel_idx = rise ? '0 : !auto ? (man_ok ? man_idx : '0) : adv ? nxt_ptr : ptr;
    assign chg     = (sel_idx != prev_idx) | (sel_ok != prev_ok);
    // up[0] masks the release cycle so the forced first load lands one cycle after it
    assign upd     = up[0] & (tick | chg | rise | adv | ~up[1]);
    assign load    = upd & ~freeze;
    assign seg_out = seg_q ^ (flip ? DP0 : '0);

    // free-running refresh divider, scroll pointer and change-detect history
    always_ff @(posedge clk) begin
        if (!reset) begin
            rcnt     <= '0;
            scnt     <= '0;
            ptr      <= '0;
            auto_q   <= 1'b0;
            up       <= '0;
            prev_idx <= '0;
            prev_ok  <= 1'b0;
        end else begin
            rcnt     <= tick ? '0 : rcnt + 1'b1;
            auto_q   <= auto;
            up       <= {up[0], 1'b1};
            prev_idx <= sel_idx;
            prev_ok  <= sel_ok;
            if (rise) begin
                scnt <= '0;
                ptr  <= '0;
            end else if (auto & tick) begin
                scnt <= adv ? '0 : scnt + 1'b1;
                ptr  <= adv ? nxt_ptr : ptr;
            end
        end
    end

    // display register: loads on update events unless frozen; DP blinks while frozen
    always_ff @(posedge clk) begin
        if (!reset) begin
            seg_q  <= DASH;
            ch_idx <= '0;
            valid  <= 1'b0;
            flip   <= 1'b0;
        end else begin
            flip <= freeze & (flip ^ tick);
            if (load) begin
                seg_q  <= sel_ok ? seg_in[sel_idx*DW +: DW] : DASH;
                valid  <= sel_ok;
                ch_idx <= sel_ok ? sel_idx : ch_idx;
            end
        end
    end
endmodule

// File: tb/tb_debug_display_mux.sv
// tb_debug_display_mux: directed scoreboard bench for debug_display_mux
module tb_debug_display_mux;
    localparam int N_CH = 4, DIGITS = 2, REFRESH_DIV = 4, SCROLL_DIV = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] seg_in;
    logic [3:0]  dsw;
    logic        auto, freeze;
    logic [15:0] seg_out;
    logic [1:0]  ch_idx;
    logic        valid;

    int total = 0, bad = 0, ec = 0;

    typedef struct {
        string       tag;
        int          at;
        logic [15:0] seg;
        logic [1:0]  idx;
        logic        vld;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    debug_display_mux #(
        .N_CH(N_CH), .DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV), .SCROLL_DIV(SCROLL_DIV)
    ) dut (
        .clk(clk), .reset(reset), .seg_in(seg_in), .dsw(dsw), .auto(auto),
        .freeze(freeze), .seg_out(seg_out), .ch_idx(ch_idx), .valid(valid)
    );

    task automatic want(string tag, int d, logic [15:0] s, logic [1:0] i, logic v);
        exp_t e;
        e.tag = tag;
        e.at  = ec + d;
        e.seg = s;
        e.idx = i;
        e.vld = v;
        q.push_back(e);
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            ec++;
            for (int i = q.size() - 1; i >= 0; i--)
                if (q[i].at == ec) begin
                    exp_t e;
                    e = q[i];
                    q.delete(i);
                    total++;
                    assert (seg_out === e.seg) else begin
                        bad++;
                        $error("FAIL %s seg_out got %h want %h", e.tag, seg_out, e.seg);
                    end
                    total++;
                    assert (ch_idx === e.idx) else begin
                        bad++;
                        $error("FAIL %s ch_idx got %0d want %0d", e.tag, ch_idx, e.idx);
                    end
                    total++;
                    assert (valid === e.vld) else begin
                        bad++;
                        $error("FAIL %s valid got %b want %b", e.tag, valid, e.vld);
                    end
                end
        end
    endtask

    initial begin
        seg_in = {16'h5678, 16'hA4F9, 16'h1234, 16'h79C0};
        dsw    = 4'b0001;
        auto   = 1'b0;
        freeze = 1'b0;
        want("rst_a", 1, 16'hBFBF, 2'd0, 1'b0);
        want("rst_b", 2, 16'hBFBF, 2'd0, 1'b0);
        want("rst_c", 3, 16'hBFBF, 2'd0, 1'b0);
        step(3);
        reset = 1'b1;
        want("rel_1", 1, 16'hBFBF, 2'd0, 1'b0);
        want("rel_2", 2, 16'h79C0, 2'd0, 1'b1);
        step(2);
        dsw = 4'b0100;
        want("man_ch2", 1, 16'hA4F9, 2'd2, 1'b1);
        step(1);
        dsw = 4'b0110;
        want("two_hot", 1, 16'hBFBF, 2'd2, 1'b0);
        step(1);
        dsw = 4'b0000;
        want("no_hot", 1, 16'hBFBF, 2'd2, 1'b0);
        step(1);
        dsw = 4'b0100;
        want("back_ch2", 1, 16'hA4F9, 2'd2, 1'b1);
        step(1);
        freeze = 1'b1;
        seg_in[47:32] = 16'h9999;
        want("frz_hold", 1, 16'hA4F9, 2'd2, 1'b1);
        want("frz_dp1", 2, 16'hA479, 2'd2, 1'b1);
        want("frz_dp1b", 5, 16'hA479, 2'd2, 1'b1);
        want("frz_dp0", 6, 16'hA4F9, 2'd2, 1'b1);
        want("frz_dp2", 10, 16'hA479, 2'd2, 1'b1);
        want("frz_dp2b", 11, 16'hA479, 2'd2, 1'b1);
        step(11);
        freeze = 1'b0;
        want("unfrz_1", 1, 16'hA4F9, 2'd2, 1'b1);
        want("unfrz_2", 2, 16'hA4F9, 2'd2, 1'b1);
        want("unfrz_tick", 3, 16'h9999, 2'd2, 1'b1);
        step(3);
        auto = 1'b1;
        dsw  = 4'b0010;
        want("auto_rise", 1, 16'h79C0, 2'd0, 1'b1);
        want("auto_hold0", 7, 16'h79C0, 2'd0, 1'b1);
        want("auto_ch1", 8, 16'h1234, 2'd1, 1'b1);
        step(4);
        dsw = 4'b1001;
        step(4);
        want("auto_ch2", 8, 16'h9999, 2'd2, 1'b1);
        step(8);
        dsw = 4'b0000;
        want("auto_ch3", 8, 16'h5678, 2'd3, 1'b1);
        step(8);
        freeze = 1'b1;
        want("auto_frz", 4, 16'h56F8, 2'd3, 1'b1);
        step(5);
        reset = 1'b0;
        want("mid_rst", 1, 16'hBFBF, 2'd0, 1'b0);
        step(1);
        reset  = 1'b1;
        freeze = 1'b0;
        want("rerel_1", 1, 16'hBFBF, 2'd0, 1'b0);
        want("rerel_2", 2, 16'h79C0, 2'd0, 1'b1);
        want("rerel_h0", 7, 16'h79C0, 2'd0, 1'b1);
        want("rerel_ch1", 8, 16'h1234, 2'd1, 1'b1);
        step(8);
        total++;
        assert (q.size() == 0) else begin
            bad++;
            $error("FAIL pending got %0d entries want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/debug_display_mux.md
DEBUG_DISPLAY_MUX -- requirements
Module: debug_display_mux

Interface
REQ-001 Parameter N_CH, 8, number of selectable measurement channels (2..16).
REQ-002 Parameter DIGITS, 2, number of 7-segment digits per channel, 8 bits each, active-low, bit 7 = DP.
REQ-003 Parameter REFRESH_DIV, 5000000, clock cycles per refresh tick (>=2).
REQ-004 Parameter SCROLL_DIV, 20, refresh ticks per channel in auto-scroll mode (>=1).
REQ-005 CLK  in  1  system clock; all state changes on rising edge.
REQ-006 RESET  in  1  synchronous, active-low reset.
REQ-007 SEG_IN  in  N_CH*DIGITS*8  flattened segment patterns; channel k occupies [k*DIGITS*8 +: DIGITS*8], digit 0 in the LSB byte.
REQ-008 DSW  in  N_CH  one-hot manual channel select; bit k selects channel k.
REQ-009 AUTO  in  1  1 = auto-scroll mode, 0 = manual mode.
REQ-010 FREEZE  in  1  1 = hold the displayed value.
REQ-011 SEG_OUT  out  DIGITS*8  registered segment patterns for the display.
REQ-012 CH_IDX  out  clog2(N_CH)  index of the channel last loaded into SEG_OUT.
REQ-013 VALID  out  1  1 = SEG_OUT holds a valid channel, 0 = dash pattern.

Function
REQ-014 Refresh counter SHALL count 0..REFRESH_DIV-1, pulse internal tick for one cycle at REFRESH_DIV-1, then wrap to 0; it runs in both modes and while frozen.
REQ-015 Manual mode: DSW with exactly one bit set SHALL select that channel; zero or more than one bit set SHALL be the invalid selection.
REQ-016 Auto mode: DSW SHALL be ignored; channel pointer SHALL advance by one every SCROLL_DIV ticks, wrapping N_CH-1 -> 0.
REQ-017 AUTO rising edge (registered compare) SHALL set pointer to 0, clear the scroll-tick counter and force an update.
REQ-018 Update event = tick, OR manual selection change (decoded index or validity differs from previous cycle), OR AUTO rising edge, OR pointer advance.
REQ-019 On an update event with FREEZE=0, SEG_OUT SHALL load the selected channel's SEG_IN slice on the next edge, with CH_IDX = channel and VALID = 1; latency from event to SEG_OUT = 1 cycle.
REQ-020 On an update event with an invalid selection, SEG_OUT SHALL load 8'b10111111 in every digit and VALID = 0; CH_IDX SHALL hold its previous value.
REQ-021 Between update events SEG_OUT, CH_IDX and VALID SHALL hold.
REQ-022 FREEZE=1 SHALL block all loads regardless of simultaneous events; pointer and scroll counters keep running in auto mode.
REQ-023 While FREEZE=1, a DP-flip register SHALL toggle on each tick, and SEG_OUT digit 0 bit 7 SHALL equal the held bit XOR flip; all other bits are unchanged.
REQ-024 FREEZE falling SHALL clear the flip register in the same edge; held value returns unmodified and the next update event loads normally.
REQ-025 Tick and selection change in the same cycle SHALL produce a single load of the new selection.
REQ-026 N_CH not a power of two: pointer SHALL never exceed N_CH-1.

Reset
REQ-027 While RESET=0 at a rising edge: SEG_OUT = all digits 8'b10111111, VALID = 0, CH_IDX = 0, refresh/scroll counters, pointer, flip register and AUTO history = 0.
REQ-028 RESET asserted mid-operation (any mode, frozen or not) SHALL take effect at the next edge, overriding all events.
REQ-029 First cycle after reset release SHALL treat the current selection as changed and load it (or dashes) one cycle later.

Verification (N_CH=4, DIGITS=2, REFRESH_DIV=4, SCROLL_DIV=2)
REQ-030 RESET=0 3 cycles, DSW=4'b0001, ch0=16'h79C0 -> SEG_OUT=16'hBFBF, VALID=0, CH_IDX=0 during reset; SEG_OUT=16'h79C0, VALID=1 two edges after release.
REQ-031 DSW 0001 -> 0100, ch2=16'hA4F9 -> SEG_OUT=16'hA4F9, CH_IDX=2 one cycle after DSW change, not waiting for tick.
REQ-032 DSW=4'b0110 or 4'b0000 -> SEG_OUT=16'hBFBF, VALID=0, CH_IDX unchanged.
REQ-033 AUTO 0->1 -> CH_IDX=0 one cycle later, then 1,2,3,0 every 8 cycles; DSW toggling has no effect.
REQ-034 FREEZE=1 holding 16'hA4F9, change ch2 to 16'h9999 -> SEG_OUT alternates 16'hA4F9/16'hA479 every 4 cycles; FREEZE=0 -> 16'hA4F9 next cycle, 16'h9999 after next tick.
REQ-035 RESET=0 for 1 cycle while AUTO=1, FREEZE=1 at CH_IDX=3 -> SEG_OUT=16'hBFBF, CH_IDX=0, flip cleared; scrolling restarts from channel 0.
